// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: FSM encoding, LFSR constants
// and parameter defaults. No logic, no latency, no backpressure of its own.
// Imported by cpu_mem_responder and responder_ram.
package cpu_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESP_I = 2'd2,
        RESP_D = 2'd3
    } state_t;

    localparam int DEF_RAM_AW       = 12;
    localparam int DEF_RESP_LATENCY = 2;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/responder_ram.sv
// Single-port 2^AW x 32 word RAM with byte-strobed write and registered read.
// Latency: read data appears on o_rdata one edge after i_re; writes land at the edge.
// Backpressure: none; caller guarantees at most one access (i_we or i_re) per cycle.
// Ports: clk, rst (clears only the read register), i_we/i_strb/i_wdata write side,
//        i_re read enable, i_addr word address, o_rdata registered read data.
module responder_ram
    import cpu_mem_responder_pkg::*;
#(
    parameter int AW = DEF_RAM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [3:0]    i_strb,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_rdata;

    // Array is intentionally not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_strb[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // This register is the response register: only loaded at read acceptance,
    // so it cannot move while a response is being presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_mem_responder.sv
// Target-side memory model for the core's fetch and data valid/ready channels.
// Latency: read accepted at edge N -> response valid from edge N+RESP_LATENCY; stores take one cycle.
// Backpressure: one request outstanding; readies low outside IDLE; data requests win over fetches.
// Ports: PC/Inst_Req_Valid/Inst_Req_Ready fetch request, Instruction/Inst_Valid/Inst_Ready
//        fetch response; Address/MemWrite/Write_data/Write_strb/MemRead/Mem_Req_Ready data
//        request, Read_data/Read_data_Valid/Read_data_Ready load response.
// Build option: define MEM_RANDOM_STALL_EN for LFSR-driven random request/latency stalls.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int RAM_AW       = DEF_RAM_AW,
    parameter int RESP_LATENCY = DEF_RESP_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    localparam logic [3:0] LAT_M1 = 4'(RESP_LATENCY - 1);

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic            r_is_fetch;
    logic            w_data_pend, w_inst_rdy, w_mem_rdy;
    logic            w_st_hs, w_ld_hs, w_if_hs, w_re;
    logic            w_stall, w_hold;
    logic [RAM_AW-1:0] w_ram_addr;
    logic [31:0]     w_rdata;
    logic            w_unused;

`ifdef MEM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign w_stall = r_lfsr[0];
    assign w_hold  = r_lfsr[1];
`else
    assign w_stall = 1'b0;
    assign w_hold  = 1'b0;
`endif

    assign w_data_pend = MemRead | MemWrite;

    // Readies are forced low while rst is asserted so nothing is accepted
    // (and no RAM write happens) during reset.
    assign w_mem_rdy  = !rst && (r_state == IDLE) && !w_stall && w_data_pend;
    assign w_inst_rdy = !rst && (r_state == IDLE) && !w_stall && !w_data_pend;

    // A store with MemRead also high is treated as a pure store.
    assign w_st_hs = MemWrite & w_mem_rdy;
    assign w_ld_hs = MemRead & ~MemWrite & w_mem_rdy;
    assign w_if_hs = Inst_Req_Valid & w_inst_rdy;
    assign w_re    = w_ld_hs | w_if_hs;

    assign w_ram_addr = w_data_pend ? Address[RAM_AW+1:2] : PC[RAM_AW+1:2];
    assign w_unused   = ^{Address[31:RAM_AW+2], Address[1:0], PC[31:RAM_AW+2], PC[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_re) begin
                    if (LAT_M1 == 4'd0) begin
                        w_state_nxt = w_if_hs ? RESP_I : RESP_D;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (!w_hold) begin
                    w_state_nxt = r_is_fetch ? RESP_I : RESP_D;
                end
            end
            RESP_I: if (Inst_Ready)      w_state_nxt = IDLE;
            RESP_D: if (Read_data_Ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_is_fetch <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_re) begin
                r_is_fetch <= w_if_hs;
            end
        end
    end

    responder_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_st_hs),
        .i_strb  (Write_strb),
        .i_re    (w_re),
        .i_addr  (w_ram_addr),
        .i_wdata (Write_data),
        .o_rdata (w_rdata)
    );

    assign Inst_Req_Ready  = w_inst_rdy;
    assign Mem_Req_Ready   = w_mem_rdy;
    assign Inst_Valid      = (r_state == RESP_I);
    assign Read_data_Valid = (r_state == RESP_D);
    assign Instruction     = w_rdata;
    assign Read_data       = w_rdata;

endmodule
